// File: rtl/lives_goal_tracker.sv
// Turns raw Bumpy collision flags into life/item counts and one-cycle
// death/win pulses, re-armed by the level manager's screen handshake.
module lives_goal_tracker #(
  parameter int INIT_LIVES = 3,
  parameter int ITEMS_BASE = 4,
  parameter int NUM_ITEMS  = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       hazard_hit,
  input  logic       item_hit,
  input  logic [2:0] item_idx,
  input  logic       reset_fsm_N,
  input  logic [2:0] lvl,
  output logic       bumpy_died,
  output logic       level_comp,
  output logic       zero_lives,
  output logic [2:0] lives,
  output logic [3:0] items_collected,
  output logic [3:0] items_required
);

  localparam logic [3:0] BASE = 4'(ITEMS_BASE);
  localparam logic [3:0] CAP  = 4'(NUM_ITEMS);
  localparam logic [2:0] L0   = 3'(INIT_LIVES);

  typedef enum logic [1:0] {
    PLAY,
    DEAD_WAIT,
    WIN_WAIT,
    GAME_OVER
  } state_t;

  state_t       state;
  logic [7:0]   bitmap;
  logic         seen_low;
  logic [3:0]   req_raw;
  logic [3:0]   cnt_next;

  // 4-bit sum so lvl=7 yields 11 before saturating
  assign req_raw = BASE + {1'b0, lvl};
  assign items_required = (req_raw > CAP) ? CAP : req_raw;
  assign cnt_next = items_collected + 4'd1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= PLAY;
      lives           <= L0;
      bumpy_died      <= 1'b0;
      level_comp      <= 1'b0;
      zero_lives      <= 1'b0;
      items_collected <= 4'd0;
      bitmap          <= 8'd0;
      seen_low        <= 1'b0;
    end else begin
      bumpy_died <= 1'b0;
      level_comp <= 1'b0;
      unique case (state)
        PLAY: begin
          if (hazard_hit) begin
            lives      <= lives - 3'd1;
            bumpy_died <= 1'b1;
            if (lives == 3'd1) begin
              zero_lives <= 1'b1;
              state      <= GAME_OVER;
            end else begin
              state <= DEAD_WAIT;
            end
          end else if (item_hit && !bitmap[item_idx]) begin
            bitmap[item_idx] <= 1'b1;
            items_collected  <= cnt_next;
            if (cnt_next == items_required) begin
              level_comp <= 1'b1;
              state      <= WIN_WAIT;
            end
          end
        end
        DEAD_WAIT, WIN_WAIT: begin
          // release only after a low-then-high screen handshake
          if (!reset_fsm_N) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            seen_low        <= 1'b0;
            bitmap          <= 8'd0;
            items_collected <= 4'd0;
            state           <= PLAY;
          end
        end
        GAME_OVER: begin
          zero_lives <= 1'b1;
          lives      <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lives_goal_tracker.sv
// Directed bench for lives_goal_tracker: hand-computed
// counts, pulses and handshake behaviour.
module tb_lives_goal_tracker;

  logic       clk = 1'b0;
  logic       resetN;
  logic       hazard_hit;
  logic       item_hit;
  logic [2:0] item_idx;
  logic       reset_fsm_N;
  logic [2:0] lvl;
  logic       bumpy_died;
  logic       level_comp;
  logic       zero_lives;
  logic [2:0] lives;
  logic [3:0] items_collected;
  logic [3:0] items_required;

  int n_cmp = 0;
  int n_err = 0;
  int died_cnt = 0;
  int comp_cnt = 0;

  always #5 clk = ~clk;

  lives_goal_tracker dut (
    .clk             (clk),
    .resetN          (resetN),
    .hazard_hit      (hazard_hit),
    .item_hit        (item_hit),
    .item_idx        (item_idx),
    .reset_fsm_N     (reset_fsm_N),
    .lvl             (lvl),
    .bumpy_died      (bumpy_died),
    .level_comp      (level_comp),
    .zero_lives      (zero_lives),
    .lives           (lives),
    .items_collected (items_collected),
    .items_required  (items_required)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      died_cnt += int'(bumpy_died);
      comp_cnt += int'(level_comp);
    end
  endtask

  task automatic screen();
    reset_fsm_N = 1'b0;
    tick(3);
    reset_fsm_N = 1'b1;
    tick(1);
  endtask

  initial begin
    resetN      = 1'b0;
    hazard_hit  = 1'b0;
    item_hit    = 1'b0;
    item_idx    = 3'd0;
    reset_fsm_N = 1'b1;
    lvl         = 3'd0;
    #22;
    check("rst_lives", lives, 3);
    check("rst_req", items_required, 4);
    check("rst_died", bumpy_died, 0);
    check("rst_comp", level_comp, 0);
    check("rst_zero", zero_lives, 0);
    check("rst_cnt", items_collected, 0);
    resetN = 1'b1;
    tick(1);

    // held overlap counts once
    comp_cnt = 0;
    item_hit = 1'b1;
    item_idx = 3'd2;
    tick(50);
    check("hold_cnt", items_collected, 1);
    check("hold_comp", comp_cnt, 0);
    item_idx = 3'd0; tick(1);
    item_idx = 3'd5; tick(1);
    item_idx = 3'd7; tick(1);
    check("win_pulse", level_comp, 1);
    check("win_cnt", items_collected, 4);
    item_hit = 1'b0;
    tick(1);
    check("win_pulse_end", level_comp, 0);
    check("win_once", comp_cnt, 1);

    // high on entry must not release; hazards ignored
    died_cnt = 0;
    hazard_hit = 1'b1;
    tick(5);
    hazard_hit = 1'b0;
    check("wait_no_died", died_cnt, 0);
    check("wait_lives", lives, 3);
    check("wait_held", items_collected, 4);
    reset_fsm_N = 1'b0;
    lvl = 3'd1;
    tick(10);
    check("lvl1_req", items_required, 5);
    check("wait_low_held", items_collected, 4);
    reset_fsm_N = 1'b1;
    tick(1);
    check("rel_cnt", items_collected, 0);
    item_hit = 1'b1;
    item_idx = 3'd3;
    tick(1);
    item_hit = 1'b0;
    check("play_again", items_collected, 1);

    // long hazard: one death
    died_cnt = 0;
    hazard_hit = 1'b1;
    tick(100);
    hazard_hit = 1'b0;
    check("death1_once", died_cnt, 1);
    check("death1_lives", lives, 2);
    check("death1_zero", zero_lives, 0);
    check("dead_keep", items_collected, 1);
    screen();
    check("death_clear", items_collected, 0);

    // hazard beats a completing item
    item_hit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      item_idx = 3'(i);
      tick(1);
    end
    check("pre_tie_cnt", items_collected, 4);
    comp_cnt = 0;
    died_cnt = 0;
    item_idx = 3'd4;
    hazard_hit = 1'b1;
    tick(1);
    hazard_hit = 1'b0;
    item_hit = 1'b0;
    check("tie_died", bumpy_died, 1);
    check("tie_comp", level_comp, 0);
    check("tie_cnt", items_collected, 4);
    check("tie_lives", lives, 1);
    tick(2);
    check("tie_comp_cnt", comp_cnt, 0);
    screen();
    check("tie_clear", items_collected, 0);

    // final life
    hazard_hit = 1'b1;
    tick(1);
    check("last_died", bumpy_died, 1);
    check("last_zero", zero_lives, 1);
    check("last_lives", lives, 0);
    died_cnt = 0;
    tick(20);
    hazard_hit = 1'b0;
    screen();
    hazard_hit = 1'b1;
    item_hit = 1'b1;
    tick(10);
    hazard_hit = 1'b0;
    item_hit = 1'b0;
    check("over_no_died", died_cnt, 0);
    check("over_lives", lives, 0);
    check("over_zero", zero_lives, 1);

    // asynchronous reset between edges
    #2;
    resetN = 1'b0;
    #1;
    check("arst_lives", lives, 3);
    check("arst_zero", zero_lives, 0);
    check("arst_cnt", items_collected, 0);
    #1;
    resetN = 1'b1;
    tick(1);

    lvl = 3'd3; #1;
    check("req_l3", items_required, 7);
    lvl = 3'd4; #1;
    check("req_l4", items_required, 8);
    lvl = 3'd7; #1;
    check("req_l7", items_required, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lives_goal_tracker.md
# lives_goal_tracker

Gameplay event tracker directly upstream of the level/screen manager. Turns raw per-cycle collision flags from the Bumpy object logic into clean one-cycle `bumpy_died` and `level_comp` pulses, the level-held `zero_lives` flag, and life and item counts for the HUD. It counts lives and per-level collected items. It re-arms only after the level manager has shown and dismissed its screen, observed as a low-then-high cycle on `reset_fsm_N`.

## Interface
- INIT_LIVES, 3: lives at power-up; range 1..7.
- ITEMS_BASE, 4: items required to complete level 0.
- NUM_ITEMS, 8: item slots per level; also the saturation cap on the required count.
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- hazard_hit  in  1  Bumpy overlaps a hazard; level signal, may stay high for many cycles.
- item_hit  in  1  Bumpy overlaps an item; level signal.
- item_idx  in  3  index of the item currently overlapped; valid only while `item_hit`=1.
- reset_fsm_N  in  1  from the level manager; low while the win or died screen is shown.
- lvl  in  3  current level from the level manager.
- bumpy_died  out  1  one-cycle pulse on a life loss.
- level_comp  out  1  one-cycle pulse when the last required item is collected.
- zero_lives  out  1  level; high once lives reach 0.
- lives  out  3  remaining lives.
- items_collected  out  4  distinct items collected in the current level attempt.
- items_required  out  4  target count, combinational from `lvl`.

## Operation
- Required count:
  - `items_required` = min(ITEMS_BASE + lvl, NUM_ITEMS).
  - Computed 4 bits wide, so lvl=7 gives 11, which saturates to 8.
- FSM has four states: PLAY, DEAD_WAIT, WIN_WAIT and GAME_OVER. Reset state is PLAY.
- PLAY, hazard:
  - On `hazard_hit`=1: `lives` decrements, `bumpy_died` pulses, and collisions are ignored from then on.
  - If the new `lives` is 0: `zero_lives`←1 and go to GAME_OVER.
  - Otherwise go to DEAD_WAIT.
- PLAY, item (applies only when `hazard_hit`=0):
  - On `item_hit`=1 with bitmap[item_idx]=0: set the bit and increment `items_collected`.
  - If the new count equals `items_required`: pulse `level_comp` and go to WIN_WAIT.
  - If the bit is already set: ignore, so a held overlap counts once.
- Simultaneous hazard and item in the same cycle: hazard wins and the item is not recorded, even if it would have completed the level.
- DEAD_WAIT and WIN_WAIT:
  - Ignore all collisions.
  - Set internal `seen_low` when `reset_fsm_N`=0.
  - On the first cycle with `reset_fsm_N`=1 and `seen_low`=1: clear the bitmap, `items_collected` and `seen_low`, then go to PLAY.
  - A death therefore restarts the level's items.
  - WIN_WAIT re-enters PLAY with `items_required` recomputed from the new `lvl`.
- GAME_OVER:
  - Absorbing until `resetN`.
  - `zero_lives`=1; `lives`=0 and never underflows.
  - No further pulses.
- `lives` never increments.

## Timing
- All outputs are registered except `items_required`.
- Reset values:
  - `lives`=INIT_LIVES.
  - `bumpy_died`, `level_comp`, `zero_lives` = 0.
  - `items_collected`=0, bitmap=0, `seen_low`=0.
  - State = PLAY.
- Latency:
  - A hit sampled at clk edge N is reflected in `lives`/`items_collected` and the pulse from edge N onward.
  - Each pulse is high for exactly one cycle.
  - `zero_lives` rises in the same cycle as the final `bumpy_died` pulse.
- At most one pulse per PLAY visit, regardless of how long the input is held.
- `reset_fsm_N` is sampled synchronously. A high level on entry to a WAIT state, before it has gone low, must not release the FSM.
- Asynchronous `resetN` mid-wait or mid-game returns everything to reset values immediately.

## Test plan
- Reset with defaults, lvl=0 → lives=3, items_required=4, all pulses 0.
- Hold `item_hit` with idx=2 for 50 cycles → items_collected=1, no `level_comp`.
  - Then idx 0, 5, 7 → `level_comp` pulses one cycle on the 4th distinct item; state WIN_WAIT.
- In WIN_WAIT:
  - Pulse `reset_fsm_N` low for 10 cycles with lvl changed to 1, then raise it → items_collected=0, items_required=5, PLAY.
  - `hazard_hit` while waiting → no effect.
- Hold `hazard_hit` for 100 cycles → exactly one `bumpy_died` pulse, lives 3→2.
  - After the `reset_fsm_N` low/high cycle, previously collected items are cleared.
- `hazard_hit` and a completing `item_hit` in the same cycle → `bumpy_died` pulses, `level_comp` stays 0, items_collected unchanged.
- Three deaths (each with a screen cycle) → third `bumpy_died` coincides with `zero_lives`=1 and lives=0.
  - Further hazards → no pulses.
  - `resetN` pulse → lives=3, zero_lives=0.
